// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// iteration mode and the divide-by-zero quotient pattern.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // Quotient reported on divide by zero; sliced to WIDTH by the user.
  localparam logic [63:0] DIVZERO_LO = '1;

endpackage

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
//   MODE_MUL: acc = {partial_hi, multiplier}; add operand when lsb set, shift right.
//   MODE_DIV: acc = {remainder, dividend/quotient}; shift left, trial subtract.
module mdu_step import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  mode_e              mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Both step flavours are evaluated; mode selects which one updates acc.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    // The extra top bit of diff is the borrow of the trial subtraction.
    diff   = rem_sh - {1'b0, opnd_i};
    qbit_o = 1'b0;
    acc_o  = '0;
    if (mode == MODE_MUL) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else begin
      qbit_o = ~diff[WIDTH];
      acc_o  = {(qbit_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], qbit_o};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Operands are reduced to magnitudes on accept, iterated WIDTH times through
// mdu_step, then sign-corrected and written to HI/LO in the FIX state.
// Build option: define MDU_SIGNED_EN for signed MULT/DIV; otherwise op 0 is
// MULTU and op 2 is DIVU and no sign logic is built.
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  mode_e                mode_q, mode_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic                 req_div;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 step_qbit;
  logic [WIDTH-1:0]     quo, rem;
  logic [2*WIDTH-1:0]   prod;

`ifdef MDU_SIGNED_EN
  logic                 neg_a, neg_b;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );

  // Operand magnitudes for the incoming request (signed ops only).
  always_comb begin
    a_abs = src_a;
    b_abs = src_b;
`ifdef MDU_SIGNED_EN
    neg_a = 1'b0;
    neg_b = 1'b0;
    if (op == OP_MULT || op == OP_DIV) begin
      neg_a = src_a[WIDTH-1];
      neg_b = src_b[WIDTH-1];
    end
    if (neg_a) a_abs = -src_a;
    if (neg_b) b_abs = -src_b;
`endif
  end

  // FSM next state, datapath update and final HI/LO correction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    req_div = (op == OP_DIV) || (op == OP_DIVU);
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    prod    = acc_q;
`ifdef MDU_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              mode_d  = req_div ? MODE_DIV : MODE_MUL;
              // Divide iterates on the dividend, multiply on the multiplier.
              acc_d   = {{WIDTH{1'b0}}, (req_div ? a_abs : b_abs)};
              opnd_d  = req_div ? b_abs : a_abs;
              dz_d    = req_div && (src_b == '0);
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = ST_CALC;
`ifdef MDU_SIGNED_EN
              neg_res_d = neg_a ^ neg_b;
              neg_rem_d = neg_a;
`endif
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        acc_d = (mode_q == MODE_DIV) ? {step_acc[2*WIDTH-1:1], step_qbit} : step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (mode_q == MODE_DIV) begin
`ifdef MDU_SIGNED_EN
          if (neg_res_q) quo = -quo;
          if (neg_rem_q) rem = -rem;
`endif
          // With a zero divisor the remainder path already yields the dividend.
          if (dz_q) quo = DIVZERO_LO[WIDTH-1:0];
          hi_d = rem;
          lo_d = quo;
        end else begin
`ifdef MDU_SIGNED_EN
          if (neg_res_q) prod = -prod;
`endif
          {hi_d, lo_d} = prod;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; synchronous active-low reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      mode_q  <= MODE_MUL;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: scoreboard of expected {hi,lo}
// pushed at issue time, popped on each done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
  exp_t sb[$];
  int   done_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result using native wide arithmetic.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, q64, r64;
    logic sgn;
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = (mop == 3'd0) || (mop == 3'd2);
`endif
    sa   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    sb64 = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    if (mop == 3'd0 || mop == 3'd1) return sa * sb64;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q64 = sa / sb64;
    r64 = sa % sb64;
    return {r64[31:0], q64[31:0]};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      done_cyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done hi=%h lo=%h required no done", hi, lo);
      end else begin
        e = sb.pop_front();
        if ({hi, lo} !== {e.hi, e.lo}) begin
          errors++;
          $display("FAIL sb_result got hi=%h lo=%h required hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
      end
    end
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout done_cnt=%0d required %0d", nm, done_cnt, target);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] ex, input string nm);
    int t;
    t = done_cnt + 1;
    push(ex[63:32], ex[31:0]);
    issue(o, a, b);
    wait_done(t, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h required 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h required 0", lo); end
    rst_n = 1'b1;
  endtask

  task automatic test_multu_latency();
    int nbusy, t;
    t = done_cnt;
    push(32'hFFFF_FFFE, 32'h0000_0001);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin nbusy++; @(negedge clk); end
    repeat (4) @(negedge clk);
    checks += 2;
    if (nbusy !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d required 33", nbusy); end
    if (done_cnt !== t + 1) begin errors++; $display("FAIL multu_done_pulses got %0d required 1", done_cnt - t); end
  endtask

  task automatic test_mul_div();
    logic [2:0] o;
    logic [31:0] a, b;
`ifdef MDU_SIGNED_EN
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_ovf");
`else
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, {32'h0000_0004, 32'hFFFF_FFF1}, "mult_neg");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, "div_neg");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, "div_ovf");
`endif
    run_op(3'd3, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, "divu_zero");
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, "div_zero");
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op(o, a, b, model(o, a, b), "random");
    end
  endtask

  task automatic test_mthi_mtlo();
    int bseen;
    bseen = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'h1234;
    @(negedge clk);
    if (busy) bseen++;
    op = 3'd5; src_a = 32'h5678;
    @(negedge clk);
    if (busy) bseen++;
    start = 1'b0;
    @(negedge clk);
    if (busy) bseen++;
    checks += 3;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h required 00001234", hi); end
    if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h required 00005678", lo); end
    if (bseen !== 0) begin errors++; $display("FAIL mt_busy got %0d busy cycles required 0", bseen); end
    // Unused op code leaves everything alone.
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    checks += 2;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      errors++; $display("FAIL nop_op got hi=%h lo=%h required 00001234/00005678", hi, lo);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy got %b required 0", busy); end
  endtask

  task automatic test_mt_mid_calc();
    int t;
    issue(3'd5, 32'hAAAA, 32'd0);
    t = done_cnt + 1;
    push(32'd0, 32'd12);
    issue(3'd1, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'h5555;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (lo !== 32'hAAAA) begin errors++; $display("FAIL mtlo_mid_calc got %h required 0000aaaa", lo); end
    if (hi !== 32'h1234) begin errors++; $display("FAIL hi_stable_calc got %h required 00001234", hi); end
    wait_done(t, "mt_mid_calc");
  endtask

  task automatic test_reset_mid();
    int t;
    issue(3'd1, 32'h1111_1111, 32'h2222_2222);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b required 0", done); end
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo got %h/%h required 0/0", hi, lo); end
    t = done_cnt + 1;
    push(32'd0, 32'd42);
    issue(3'd1, 32'd6, 32'd7);
    wait_done(t, "after_reset");
  endtask

  task automatic test_back_to_back();
    int t, n, gap;
    t = done_cnt;
    push(32'd6, 32'd142);
    push(32'd2, 32'd16);
    @(negedge clk);
    start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    src_a = 32'd50; src_b = 32'd3;
    n = 0;
    while (done_cnt < t + 1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept busy=%b required 1", busy); end
    wait_done(t + 2, "b2b");
    gap = (done_cyc.size() >= t + 2) ? done_cyc[t + 1] - done_cyc[t] : -1;
    checks++;
    if (gap !== 34) begin errors++; $display("FAIL b2b_gap got %0d required 34", gap); end
  endtask

  initial begin
    test_reset();
    test_multu_latency();
    test_mul_div();
    test_mthi_mtlo();
    test_mt_mid_calc();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
